// File: rtl/capsense_pkg.sv
// rtl/capsense_pkg.sv - shared definitions for the CapSense controller and pad emulator
// Contents:
//   chan_state_e : per-pad charge state
//   mod_samp()   : clocks per 1.5 MHz sample tick for a given MHz clock
//   mod_bits()   : prescaler width needed to count 0..mod_samp-1
package capsense_pkg;

  typedef enum logic [1:0] {
    DISCHARGED = 2'd0,
    CHARGING   = 2'd1,
    CHARGED    = 2'd2
  } chan_state_e;

  // freq / 1.5 rounded down, done in integers as freq*2/3.
  function automatic int mod_samp(input int freq);
    return (freq * 2) / 3;
  endfunction

  // A one-clock tick period still needs a 1-bit prescaler.
  function automatic int mod_bits(input int ms);
    return (ms <= 1) ? 1 : $clog2(ms);
  endfunction

  localparam int DEF_FREQUENCY = 24;
  localparam int DEF_MOD_SAMP  = mod_samp(DEF_FREQUENCY);
  localparam int DEF_MOD_BITS  = mod_bits(DEF_MOD_SAMP);

endpackage

// File: rtl/capsense_pad_chan.sv
// rtl/capsense_pad_chan.sv - one emulated capacitive pad channel
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : one-cycle sample tick from the shared prescaler
//   start        : charge start edge (discharge strobe just released)
//   oe           : discharge strobe as sampled this cycle; overrides everything
//   touch        : touched flag, latched only on start
//   pad          : registered pad level
//   charging     : channel is currently CHARGING
//   charging_nxt : channel will be CHARGING after this edge
//   rise         : channel moves CHARGING -> CHARGED on this edge
module capsense_pad_chan
  import capsense_pkg::*;
#(
  parameter int T_FREE   = 3,
  parameter int T_TOUCH  = 20,
  parameter int CNT_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic start,
  input  logic oe,
  input  logic touch,
  output logic pad,
  output logic charging,
  output logic charging_nxt,
  output logic rise
);

  chan_state_e         state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic                touch_r, touch_nxt;
  logic [CNT_BITS-1:0] thr;

  assign thr          = touch_r ? CNT_BITS'(T_TOUCH) : CNT_BITS'(T_FREE);
  assign charging     = (state == CHARGING);
  assign charging_nxt = (state_nxt == CHARGING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DISCHARGED;
      cnt     <= '0;
      touch_r <= 1'b0;
      pad     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      touch_r <= touch_nxt;
      // Pad is its own flop so the output never glitches on state decode.
      pad     <= (state_nxt == CHARGED);
    end
  end

  // Priority: oe (discharge) beats start beats tick, so a strobe landing on
  // a threshold tick keeps the pad low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    touch_nxt = touch_r;
    rise      = 1'b0;
    if (oe) begin
      state_nxt = DISCHARGED;
      cnt_nxt   = '0;
    end else if (start) begin
      state_nxt = CHARGING;
      cnt_nxt   = '0;
      touch_nxt = touch;
    end else if ((state == CHARGING) && tick) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt_nxt == thr) begin
        state_nxt = CHARGED;
        rise      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/capsense_pad_emu.sv
// rtl/capsense_pad_emu.sv - emulator of N capacitive touch pads for the CapSense controller
// Ports:
//   clk_i    : system clock
//   rst_i    : asynchronous active-low reset
//   oe_i     : discharge strobe; 1 holds pads low, 1->0 starts a charge
//   touch_i  : per-pad touched flag, latched at charge start
//   pad_o    : emulated pad levels
//   busy_o   : some pad is still charging
//   done_o   : one-cycle pulse when the last charging pad rises
module capsense_pad_emu
  import capsense_pkg::*;
#(
  parameter int N         = 4,
  parameter int FREQUENCY = 24,
  parameter int T_FREE    = 3,
  parameter int T_TOUCH   = 20,
  parameter int CNT_BITS  = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         oe_i,
  input  logic [N-1:0] touch_i,
  output logic [N-1:0] pad_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int MOD_SAMP = mod_samp(FREQUENCY);
  localparam int MOD_BITS = mod_bits(MOD_SAMP);

  if (MOD_SAMP < 1) begin : g_bad_freq
    $error("capsense_pad_emu: FREQUENCY too low for a 1.5 MHz tick");
  end
  if (T_FREE < 1) begin : g_bad_free
    $error("capsense_pad_emu: T_FREE must be at least 1");
  end
  if (T_TOUCH <= T_FREE) begin : g_bad_order
    $error("capsense_pad_emu: T_TOUCH must exceed T_FREE");
  end
  if (T_TOUCH >= (1 << CNT_BITS)) begin : g_bad_width
    $error("capsense_pad_emu: T_TOUCH does not fit in CNT_BITS");
  end

  logic                oe_r;
  logic                start;
  logic                tick;
  logic [MOD_BITS-1:0] presc;
  logic [N-1:0]        charging;
  logic [N-1:0]        charging_nxt;
  logic [N-1:0]        rise;

  // oe_r resets to 1 so oe_i already low at reset release counts as a start.
  assign start = oe_r & ~oe_i;
  assign tick  = (presc == MOD_BITS'(MOD_SAMP - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      oe_r  <= 1'b1;
      presc <= '0;
    end else begin
      oe_r <= oe_i;
      if (start || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + MOD_BITS'(1);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    capsense_pad_chan #(
      .T_FREE   (T_FREE),
      .T_TOUCH  (T_TOUCH),
      .CNT_BITS (CNT_BITS)
    ) u_chan (
      .clk          (clk_i),
      .rst_n        (rst_i),
      .tick         (tick),
      .start        (start),
      .oe           (oe_i),
      .touch        (touch_i[i]),
      .pad          (pad_o[i]),
      .charging     (charging[i]),
      .charging_nxt (charging_nxt[i]),
      .rise         (rise[i])
    );
  end

  // done fires only when the final charging pads rise together; an oe abort
  // empties the charging set without any rise, so it produces no pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= |charging_nxt;
      done_o <= (|charging) & ~(|charging_nxt) & (|rise);
    end
  end

endmodule

// File: tb/tb_capsense_pad_emu.sv
// tb/tb_capsense_pad_emu.sv - self-checking bench for capsense_pad_emu
module tb_capsense_pad_emu;

  localparam int N       = 4;
  localparam int FREQ    = 24;
  localparam int MS      = 16;
  localparam int T_FREE  = 3;
  localparam int T_TOUCH = 20;

  logic         clk;
  logic         rst_i;
  logic         oe_i;
  logic [N-1:0] touch_i;
  logic [N-1:0] pad_o;
  logic         busy_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  capsense_pad_emu #(
    .N         (N),
    .FREQUENCY (FREQ),
    .T_FREE    (T_FREE),
    .T_TOUCH   (T_TOUCH),
    .CNT_BITS  (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .oe_i    (oe_i),
    .touch_i (touch_i),
    .pad_o   (pad_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs k edges after start edge E, for latched touch t;
  // oe driven high just after edge E+abort_k (abort_k < 0: never).
  function automatic void model(input logic [N-1:0] t, input int k, input int abort_k,
                                output logic [N-1:0] pad, output logic busy,
                                output logic done);
    int rise_at [N];
    int last;
    bit alive;
    last = 0;
    for (int i = 0; i < N; i++) begin
      rise_at[i] = (t[i] ? T_TOUCH : T_FREE) * MS;
      if (rise_at[i] > last) last = rise_at[i];
    end
    alive = (abort_k < 0) || (k <= abort_k);
    for (int i = 0; i < N; i++) pad[i] = alive && (k >= rise_at[i]);
    busy = alive && (k < last);
    done = alive && (k == last);
  endfunction

  // Called just after edge E; checks every cycle up to E+len.
  task automatic track(input string tag, input logic [N-1:0] t, input int late_k,
                       input logic [N-1:0] t_late, input int abort_k, input int len);
    logic [N-1:0] ep;
    logic eb, ed;
    for (int k = 0; k <= len; k++) begin
      model(t, k, abort_k, ep, eb, ed);
      chk({tag, "_pad"}, 32'(pad_o), 32'(ep));
      chk({tag, "_busy"}, 32'(busy_o), 32'(eb));
      chk({tag, "_done"}, 32'(done_o), 32'(ed));
      if (k == late_k) touch_i = t_late;
      if (k == abort_k) oe_i = 1'b1;
      step(1);
    end
  endtask

  task automatic start_charge(input logic [N-1:0] t);
    oe_i = 1'b1;
    step(2);
    touch_i = t;
    oe_i    = 1'b0;
    step(1);
  endtask

  task automatic discharge(input string tag);
    oe_i = 1'b1;
    step(1);
    chk({tag, "_dis_pad"}, 32'(pad_o), 32'(0));
    chk({tag, "_dis_busy"}, 32'(busy_o), 32'(0));
  endtask

  initial begin
    logic [N-1:0] rt;
    int ab;

    // 1: reset with oe high, then idle
    rst_i   = 1'b0;
    oe_i    = 1'b1;
    touch_i = '0;
    #23;
    chk("rst_pad", 32'(pad_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_done", 32'(done_o), 32'(0));
    rst_i = 1'b1;
    for (int c = 0; c < 500; c++) begin
      step(1);
      chk("idle_pad", 32'(pad_o), 32'(0));
      chk("idle_busy", 32'(busy_o), 32'(0));
      chk("idle_done", 32'(done_o), 32'(0));
    end

    // 2: all untouched
    start_charge(4'b0000);
    track("free", 4'b0000, -1, 4'b0000, -1, 60);
    discharge("free");

    // 3: mixed touch
    start_charge(4'b0101);
    track("mixed", 4'b0101, -1, 4'b0101, -1, 330);
    discharge("mixed");

    // 4: abort at E+100
    start_charge(4'b0001);
    track("abort", 4'b0001, -1, 4'b0001, 100, 340);
    discharge("abort");

    // abort exactly on the untouched threshold edge: oe wins
    start_charge(4'b0000);
    track("abort_thr", 4'b0000, -1, 4'b0000, 47, 60);
    discharge("abort_thr");

    // 5: touch change mid-charge ignored
    start_charge(4'b0000);
    track("late", 4'b0000, 10, 4'b1111, -1, 60);
    discharge("late");

    // 6: async reset mid-charge, then restart at release
    start_charge(4'b1111);
    track("pre_rst", 4'b1111, -1, 4'b1111, -1, 200);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_pad", 32'(pad_o), 32'(0));
    chk("async_rst_busy", 32'(busy_o), 32'(0));
    chk("async_rst_done", 32'(done_o), 32'(0));
    oe_i = 1'b0;
    step(1);
    chk("in_rst_busy", 32'(busy_o), 32'(0));
    rst_i = 1'b1;
    step(1);
    track("post_rst", 4'b1111, -1, 4'b1111, -1, 330);

    // reset while pads are high
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_high_pad", 32'(pad_o), 32'(0));
    oe_i = 1'b1;
    step(1);
    rst_i = 1'b1;
    step(2);
    chk("rst_high_idle", 32'(pad_o), 32'(0));

    // 7 / random: random touch patterns, sometimes aborted
    for (int r = 0; r < 6; r++) begin
      rt = N'($urandom);
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 330)) : -1;
      start_charge(rt);
      track("rand", rt, -1, rt, ab, 330);
      // a non-aborted charge leaves touched pads low: pad == ~touch at E+48
      discharge("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capsense_pad_emu.md
# capsense_pad_emu

Synthesizable emulator of N capacitive touch pads, the counterpart of the CapSense sampling controller. It receives the controller's pad output-enable (discharge) strobe and drives the pad inputs back, with each pad's rise delay chosen by a per-pad "touched" flag. It is used for on-FPGA loopback demos and as the self-checking partner of the controller in benches, so that no analog pads are required.

## Interface
- `N`, 4: number of emulated pads.
- `FREQUENCY`, 24: clock frequency in MHz. The tick period is `MOD_SAMP = FREQUENCY/1.5` clocks, the same 1.5 MHz rate the controller samples at.
- `T_FREE`, 3: charge time of an untouched pad, in ticks. Must be at least 1.
- `T_TOUCH`, 20: charge time of a touched pad, in ticks. Must satisfy `T_TOUCH > T_FREE` and `T_TOUCH < 2^CNT_BITS`.
- `CNT_BITS`, 8: width of the per-pad tick counter.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `oe_i`  in  1  discharge strobe from the controller. 1 = hold every pad low; 1→0 = start a charge.
- `touch_i`  in  N  per-pad touched flag. Sampled only at the charge start.
- `pad_o`  out  N  emulated pad levels, fed to the controller's button inputs.
- `busy_o`  out  1  1 while any pad is charging.
- `done_o`  out  1  one-cycle pulse when the last pad of a charge finishes.

## Operation
- `oe_r` registers `oe_i`. Its reset value is 1, so `oe_i` held low as reset releases starts a charge.
- **Start edge E:** the first clock edge where `oe_r=1` and `oe_i=0`. At E:
  - the prescaler is cleared to 0;
  - every pad counter is cleared to 0;
  - `touch_i` is latched into `touch_r`;
  - every channel moves to CHARGING.
- **Prescaler:** counts 0..`MOD_SAMP-1`. `tick` is asserted while the prescaler equals `MOD_SAMP-1`, then it wraps to 0.
- **Per-channel states:**
  - DISCHARGED: `pad_o[i]=0`.
  - CHARGING: on each tick, the counter increments. When `cnt+1 == thr`, with `thr = touch_r[i] ? T_TOUCH : T_FREE`, the channel moves to CHARGED and `pad_o[i]` goes to 1 at that same edge.
  - CHARGED: `pad_o[i]=1` and the counter holds.
- **`oe_i` high (sampled 1):**
  - every channel goes to DISCHARGED on the next edge, whatever its state;
  - the counters clear;
  - `busy_o` and `pad_o` go to 0.
  - If `oe_i` is high on the same edge as a tick or a threshold hit, `oe_i` wins: no pad rises.
- **`busy_o`** = OR over channels of (state == CHARGING). It is registered.
- **`done_o`** = 1 for exactly one cycle, on the edge where the last CHARGING channel moves to CHARGED.
  - If several pads reach threshold on the same edge, still only one pulse is produced.
  - No pulse if the charge was aborted by `oe_i`.
- `touch_i` changes while charging have no effect until the next start edge.
- A new start edge while some channels are still CHARGED (oe pulse shorter than one cycle is impossible) follows the normal rules; nothing special is needed.

## Timing
- **Reset values:** `pad_o=0`, `busy_o=0`, `done_o=0`, all channels DISCHARGED, prescaler 0, `oe_r=1`.
- **Reset assertion:** applies asynchronously at any point, including mid-charge.
- **Rise time:** pad i rises at edge `E + thr*MOD_SAMP`.
  - FREQUENCY=24 gives MOD_SAMP=16.
  - Untouched: E+48. Touched: E+320.
- **`busy_o`:** rises at E+1 as seen by registered logic. It is 1 in the cycle following E.
- **Fall latency:** `pad_o` falls one edge after `oe_i` is sampled high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `capsense_pkg`:**
  - channel state enum (DISCHARGED, CHARGING, CHARGED);
  - function `mod_samp(freq)` returning `freq/1.5` rounded down, shared with the controller;
  - `MOD_BITS` derivation.
- **Sub-module `capsense_pad_chan`:** one per pad, generated N times. It holds the state, the counter, `touch_r` and `pad_o[i]`. Its inputs are `tick`, `start` and `oe`.
- **Top level:** the prescaler, edge detect, `busy_o`/`done_o` reduction and parameter assertions.

## Test plan
1. Reset with `oe_i=1`, `touch_i=0000` → `pad_o=0000`, `busy_o=0`, `done_o=0`. Hold 500 cycles: nothing changes.
2. `oe_i` 1→0, `touch_i=0000` → all four pads rise at E+48; `done_o` pulses once at E+48; `busy_o` falls at E+48.
3. `oe_i` 1→0, `touch_i=0101` → pads 1 and 3 rise at E+48; pads 0 and 2 rise at E+320; a single `done_o` pulse at E+320.
4. `touch_i=0001`, `oe_i` returns to 1 at E+100 → `pad_o` becomes 0000 at E+101; pad 0 never rises; no `done_o`; `busy_o` is 0 from E+101.
5. `touch_i=0000` at E, switched to 1111 at E+10 → all pads still rise at E+48.
6. `rst_i` pulled low at E+200 with `touch_i=1111` → `pad_o=0`, `busy_o=0` immediately. Release with `oe_i=0` → a new charge starts on the first edge after release; with `touch_i` still 1111, pads rise 320 cycles later.
7. Loopback with the controller: pads touched per `touch_i` → the controller's `buttons_o` equals `touch_i` after one poll period.
